oven_time_setter: RTL and testbench

//  Front-end for the oven countdown timer: conditions the two active-low keys and holds the

---
 rtl/oven_time_setter_if.sv | 24 ++
 rtl/oven_time_setter.sv | 250 +++++++++++++++++++++++++
 tb/tb_oven_time_setter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/oven_time_setter_if.sv
// Key inputs and BCD setpoint outputs of the oven time setter.
// The master drives the keys and mode select; the slave returns the digits.
`timescale 1ns/1ps
interface oven_time_setter_if;
  logic       button1;
  logic       button2;
  logic       toggle_set;
  logic [3:0] sec_ones;
  logic [2:0] sec_tens;
  logic [3:0] min_ones;
  logic [2:0] min_tens;
  logic       set_changed;
  logic       nonzero;

  modport master (
    output button1, button2, toggle_set,
    input  sec_ones, sec_tens, min_ones, min_tens, set_changed, nonzero
  );

  modport slave (
    input  button1, button2, toggle_set,
    output sec_ones, sec_tens, min_ones, min_tens, set_changed, nonzero
  );
endinterface

// File: rtl/oven_time_setter.sv
// Debounced inc/dec keys editing a saturating MM:SS cook-time setpoint (00:00..59:59).
// Auto-repeat while a key is held is built only when REPEAT_EN is defined.
`timescale 1ns/1ps
module oven_time_setter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int STEP_SEC        = 5
) (
  input  logic              clk,
  input  logic              rst,
  oven_time_setter_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  // An out-of-range configuration degrades to 1-second steps rather than corrupting the digits.
  localparam bit CFG_OK = (STEP_SEC >= 1) && (STEP_SEC <= 9) &&
                          (REPEAT_DELAY >= 1) && (REPEAT_RATE >= 1);
  localparam logic [11:0] STEP_AMT = CFG_OK ? 12'(STEP_SEC) : 12'd1;
  localparam logic [11:0] MAX_SEC  = 12'd3599;

`ifdef REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LOAD = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LOAD  = RPT_W'(REPEAT_RATE - 1);
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_INC = 2'd1,
    HOLD_DEC = 2'd2,
    BLOCKED  = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
  } mmss_t;

  function automatic mmss_t to_mmss(input logic [11:0] secs);
    mmss_t       r;
    logic [11:0] mins;
    logic [11:0] rem;
    mins       = secs / 12'd60;
    rem        = secs - (mins * 12'd60);
    r.min_tens = 3'(mins / 12'd10);
    r.min_ones = 4'(mins % 12'd10);
    r.sec_tens = 3'(rem / 12'd10);
    r.sec_ones = 4'(rem % 12'd10);
    return r;
  endfunction

  // Bit 0 carries the increment key (button1), bit 1 the decrement key (button2).
  logic [1:0]      sync1_r;
  logic [1:0]      sync2_r;
  logic [1:0]      db_r;
  logic [1:0]      db_prev_r;
  logic [DB_W-1:0] db_cnt_r [2];
  logic [1:0]      press_s;

  state_t          state_r;
  state_t          state_s;
  logic            step_inc_s;
  logic            step_dec_s;
`ifdef REPEAT_EN
  logic [RPT_W-1:0] rpt_cnt_r;
  logic [RPT_W-1:0] rpt_cnt_s;
`endif

  logic [11:0]     secs_r;
  logic [11:0]     secs_s;
  mmss_t           digits_r;
  logic            set_changed_r;
  logic            nonzero_r;

  // Key synchronizers and per-key debounce counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r     <= 2'b11;
      sync2_r     <= 2'b11;
      db_r        <= 2'b11;
      db_prev_r   <= 2'b11;
      db_cnt_r[0] <= DB_W'(0);
      db_cnt_r[1] <= DB_W'(0);
    end else begin
      sync1_r   <= {bus.button2, bus.button1};
      sync2_r   <= sync1_r;
      db_prev_r <= db_r;
      for (int k = 0; k < 2; k++) begin
        if (sync2_r[k] == db_r[k]) begin
          db_cnt_r[k] <= DB_W'(0);
        end else if (db_cnt_r[k] == DB_LAST) begin
          db_r[k]     <= sync2_r[k];
          db_cnt_r[k] <= DB_W'(0);
        end else begin
          db_cnt_r[k] <= db_cnt_r[k] + DB_W'(1);
        end
      end
    end
  end

  assign press_s = db_prev_r & ~db_r;

  // Key FSM: decides when a step is issued and which direction.
  always_comb begin
    state_s    = state_r;
    step_inc_s = 1'b0;
    step_dec_s = 1'b0;
`ifdef REPEAT_EN
    rpt_cnt_s  = RPT_W'(0);
`endif
    if (bus.toggle_set) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          // A press only counts as "alone" when the other key is released.
          if (press_s[0] && db_r[1]) begin
            step_inc_s = 1'b1;
            state_s    = HOLD_INC;
`ifdef REPEAT_EN
            rpt_cnt_s  = DELAY_LOAD;
`endif
          end else if (press_s[1] && db_r[0]) begin
            step_dec_s = 1'b1;
            state_s    = HOLD_DEC;
`ifdef REPEAT_EN
            rpt_cnt_s  = DELAY_LOAD;
`endif
          end else if (press_s[0] || press_s[1]) begin
            state_s = BLOCKED;
          end else begin
            state_s = IDLE;
          end
        end
        HOLD_INC: begin
          if (db_r[0]) begin
            state_s = IDLE;
          end else if (!db_r[1]) begin
            state_s = BLOCKED;
          end else begin
            state_s = HOLD_INC;
`ifdef REPEAT_EN
            if (rpt_cnt_r == RPT_W'(0)) begin
              step_inc_s = 1'b1;
              rpt_cnt_s  = RATE_LOAD;
            end else begin
              rpt_cnt_s  = rpt_cnt_r - RPT_W'(1);
            end
`endif
          end
        end
        HOLD_DEC: begin
          if (db_r[1]) begin
            state_s = IDLE;
          end else if (!db_r[0]) begin
            state_s = BLOCKED;
          end else begin
            state_s = HOLD_DEC;
`ifdef REPEAT_EN
            if (rpt_cnt_r == RPT_W'(0)) begin
              step_dec_s = 1'b1;
              rpt_cnt_s  = RATE_LOAD;
            end else begin
              rpt_cnt_s  = rpt_cnt_r - RPT_W'(1);
            end
`endif
          end
        end
        BLOCKED: begin
          if (db_r[0] && db_r[1]) begin
            state_s = IDLE;
          end else begin
            state_s = BLOCKED;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

`ifdef REPEAT_EN
  // Auto-repeat interval counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_cnt_r <= RPT_W'(0);
    end else begin
      rpt_cnt_r <= rpt_cnt_s;
    end
  end
`endif

  // Saturating next setpoint in seconds.
  always_comb begin
    secs_s = secs_r;
    if (step_inc_s) begin
      if (secs_r > (MAX_SEC - STEP_AMT)) begin
        secs_s = MAX_SEC;
      end else begin
        secs_s = secs_r + STEP_AMT;
      end
    end else if (step_dec_s) begin
      if (secs_r < STEP_AMT) begin
        secs_s = 12'd0;
      end else begin
        secs_s = secs_r - STEP_AMT;
      end
    end else begin
      secs_s = secs_r;
    end
  end

  // Setpoint, digits and flags all register from the same next value so they stay consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      secs_r        <= 12'd0;
      digits_r      <= '{3'd0, 4'd0, 3'd0, 4'd0};
      set_changed_r <= 1'b0;
      nonzero_r     <= 1'b0;
    end else begin
      secs_r        <= secs_s;
      digits_r      <= to_mmss(secs_s);
      set_changed_r <= (secs_s != secs_r);
      nonzero_r     <= (secs_s != 12'd0);
    end
  end

  assign bus.sec_ones    = digits_r.sec_ones;
  assign bus.sec_tens    = digits_r.sec_tens;
  assign bus.min_ones    = digits_r.min_ones;
  assign bus.min_tens    = digits_r.min_tens;
  assign bus.set_changed = set_changed_r;
  assign bus.nonzero     = nonzero_r;

endmodule

// File: tb/tb_oven_time_setter.sv
// Self-checking bench for oven_time_setter: directed scenarios plus randomized key
// sequences checked against a seconds-level model of the setpoint.
`timescale 1ns/1ps
module tb_oven_time_setter;

  localparam int DEB    = 4;
  localparam int RD     = 20;
  localparam int RR     = 8;
  localparam int STEP   = 5;
  localparam int SETTLE = 12;

  logic clk = 1'b0;
  logic rst;

  oven_time_setter_if bus ();

  oven_time_setter #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .STEP_SEC       (STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int model_secs = 0;
  int exp_pulses = 0;
  int pulses = 0;
  int cyc = 0;
  int pulse_cyc[$];

  // set_changed monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.set_changed === 1'b1) begin
      pulses <= pulses + 1;
      pulse_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Number of auto-repeat steps for a key held n cycles: repeats fire at RD, RD+RR, ...
  // cycles after the press while the key is still held.
  function automatic int repeats_for(input int n);
`ifdef REPEAT_EN
    if (n > RD) return 1 + (n - RD - 1) / RR;
    else return 0;
`else
    return 0;
`endif
  endfunction

  task automatic model_step(input int delta);
    int nv;
    nv = model_secs + delta;
    if (nv > 3599) nv = 3599;
    if (nv < 0) nv = 0;
    if (nv != model_secs) exp_pulses++;
    model_secs = nv;
  endtask

  // which: 1 = inc only, 2 = dec only, 3 = both together (blocked, no step).
  task automatic model_press(input int which, input int hold);
    if (which == 1 || which == 2) begin
      repeat (1 + repeats_for(hold)) model_step((which == 1) ? STEP : -STEP);
    end
  endtask

  task automatic key_hold(input int which, input int hold);
    bus.button1 = ((which & 1) != 0) ? 1'b0 : 1'b1;
    bus.button2 = ((which & 2) != 0) ? 1'b0 : 1'b1;
    wait_cyc(hold);
    bus.button1 = 1'b1;
    bus.button2 = 1'b1;
    wait_cyc(SETTLE);
  endtask

  task automatic check_all(input string tag);
    chk({tag, " sec_ones"}, 32'(bus.sec_ones), 32'((model_secs % 60) % 10));
    chk({tag, " sec_tens"}, 32'(bus.sec_tens), 32'((model_secs % 60) / 10));
    chk({tag, " min_ones"}, 32'(bus.min_ones), 32'((model_secs / 60) % 10));
    chk({tag, " min_tens"}, 32'(bus.min_tens), 32'(model_secs / 600));
    chk({tag, " nonzero"}, 32'(bus.nonzero), 32'(model_secs != 0));
    chk({tag, " pulses"}, 32'(pulses), 32'(exp_pulses));
  endtask

  initial begin
    int base;
    int n;
    int c0;
    int kind;
    int hold;
    int p0;

    rst = 1'b1;
    bus.button1 = 1'b1;
    bus.button2 = 1'b1;
    bus.toggle_set = 1'b0;
    wait_cyc(3);
    check_all("reset");
    chk("reset set_changed", 32'(bus.set_changed), 32'd0);
    rst = 1'b0;
    wait_cyc(2);

    // 1: single press
    key_hold(1, 10);
    model_press(1, 10);
    check_all("t1 press");

    // 2: bouncing key never settles
    repeat (5) begin
      bus.button1 = 1'b0;
      wait_cyc(2);
      bus.button1 = 1'b1;
      wait_cyc(2);
    end
    wait_cyc(SETTLE);
    check_all("t2 bounce");

    // 3: long hold, auto-repeat timing
    base = pulse_cyc.size();
    c0 = cyc;
    key_hold(1, 58);
    model_press(1, 58);
    n = pulse_cyc.size() - base;
    chk("t3 step count", 32'(n), 32'(1 + repeats_for(58)));
    if (n > 0) begin
      chk("t3 first step latency", 32'((pulse_cyc[base] - c0) <= (2 + DEB + 4)), 32'd1);
    end
    for (int i = 1; i < n; i++) begin
      chk("t3 repeat offset", 32'(pulse_cyc[base + i] - pulse_cyc[base]), 32'(RD + (i - 1) * RR));
    end
    check_all("t3 hold");

    // 4: saturation at both ends
    while (model_secs < 3595) begin
      key_hold(1, 4);
      model_press(1, 4);
    end
    check_all("t4 59:55");
    key_hold(1, 6);
    model_press(1, 6);
    check_all("t4 59:59");
    p0 = pulses;
    key_hold(1, 6);
    model_press(1, 6);
    check_all("t4 inc at max");
    chk("t4 no pulse at max", 32'(pulses - p0), 32'd0);
    while (model_secs > 4) begin
      key_hold(2, 4);
      model_press(2, 4);
    end
    check_all("t4 00:04");
    key_hold(2, 6);
    model_press(2, 6);
    check_all("t4 dec to zero");
    p0 = pulses;
    key_hold(2, 6);
    model_press(2, 6);
    check_all("t4 dec at zero");
    chk("t4 no pulse at zero", 32'(pulses - p0), 32'd0);

    // 5: conflicting keys block stepping
    bus.button1 = 1'b0;
    wait_cyc(10);
    model_step(STEP);
    bus.button2 = 1'b0;
    wait_cyc(30);
    check_all("t5 blocked");
    bus.button1 = 1'b1;
    wait_cyc(30);
    check_all("t5 inc released only");
    bus.button2 = 1'b1;
    wait_cyc(SETTLE);
    key_hold(2, 6);
    model_press(2, 6);
    check_all("t5 dec after release");

    // 6: run mode freezes, reset mid-hold clears
    key_hold(1, 6);
    model_press(1, 6);
    bus.toggle_set = 1'b1;
    wait_cyc(2);
    bus.button1 = 1'b0;
    bus.button2 = 1'b0;
    wait_cyc(100);
    check_all("t6 run mode hold");
    rst = 1'b1;
    wait_cyc(1);
    chk("t6 rst sec_ones", 32'(bus.sec_ones), 32'd0);
    chk("t6 rst sec_tens", 32'(bus.sec_tens), 32'd0);
    chk("t6 rst min_ones", 32'(bus.min_ones), 32'd0);
    chk("t6 rst min_tens", 32'(bus.min_tens), 32'd0);
    chk("t6 rst nonzero", 32'(bus.nonzero), 32'd0);
    chk("t6 rst set_changed", 32'(bus.set_changed), 32'd0);
    rst = 1'b0;
    model_secs = 0;
    bus.button1 = 1'b1;
    bus.button2 = 1'b1;
    wait_cyc(SETTLE);
    bus.toggle_set = 1'b0;
    wait_cyc(2);
    check_all("t6 after rst");

    // 6b: key held across run->set does not step until re-pressed
    bus.toggle_set = 1'b1;
    bus.button1 = 1'b0;
    wait_cyc(20);
    bus.toggle_set = 1'b0;
    wait_cyc(30);
    check_all("t6 held across toggle");
    bus.button1 = 1'b1;
    wait_cyc(SETTLE);
    key_hold(1, 6);
    model_press(1, 6);
    check_all("t6 re-press");

    // Randomized key sequences
    for (int it = 0; it < 30; it++) begin
      kind = int'($urandom_range(0, 5));
      hold = int'($urandom_range(DEB, 50));
      case (kind)
        0, 1: begin
          key_hold(1, hold);
          model_press(1, hold);
        end
        2: begin
          key_hold(2, hold);
          model_press(2, hold);
        end
        3: begin
          key_hold(3, hold);
        end
        4: begin
          key_hold(int'($urandom_range(1, 2)), int'($urandom_range(1, DEB - 1)));
        end
        default: begin
          bus.toggle_set = 1'b1;
          wait_cyc(2);
          key_hold(int'($urandom_range(1, 3)), hold);
          bus.toggle_set = 1'b0;
          wait_cyc(2);
        end
      endcase
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
